// File: rtl/planificador_acciones_pkg.sv
// Shared action ids, FSM encoding and round-robin helper for the action scheduler
// and the needs datapath that consumes its offers.
package planificador_acciones_pkg;

    localparam logic [2:0] ACC_TICK        = 3'd0;
    localparam logic [2:0] ACC_REGAR       = 3'd1;
    localparam logic [2:0] ACC_ABONAR      = 3'd2;
    localparam logic [2:0] ACC_PODAR       = 3'd3;
    localparam logic [2:0] ACC_REPOSAR     = 3'd4;
    localparam logic [2:0] ACC_INTERACCION = 3'd5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARB   = 2'd1;
    localparam logic [1:0] ST_OFFER = 2'd2;

    // First pending id at or after ptr, wrapping 5 -> 1; ptr is always in 1..5.
    function automatic logic [2:0] rr_pick(input logic [5:1] pend, input logic [2:0] ptr);
        logic [7:0] p;
        logic [3:0] c;
        logic       found;
        p       = {2'b00, pend, 1'b0};
        rr_pick = ACC_REGAR;
        found   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            c = {1'b0, ptr} + 4'(k);
            if (c > 4'd5) c = c - 4'd5;
            if (!found && p[c[2:0]]) begin
                rr_pick = c[2:0];
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/planificador_acciones_detector_flanco.sv
// Rising-edge detector: combinational pulse while level is high and its registered copy low.
// Reset loads the current level so an input already held high does not fire.
module detector_flanco (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic flanco
);

    logic prev;

    always_ff @(posedge clk) begin
        if (reset) prev <= level;
        else       prev <= level;
    end

    assign flanco = level & ~prev;

endmodule

// File: rtl/planificador_acciones.sv
// Action scheduler: edge-captured requests arbitrated (tick first, then round-robin) and offered
// on valid/ready; edge at n -> valid at n+3 when idle; offer holds until accion_ready, edges still captured.
module planificador_acciones #(
    parameter int COOLDOWN_S = 2,
    parameter int TICK_MAX   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       passsecond,
    input  logic       botonregar,
    input  logic       botonabonar,
    input  logic       botonpodar,
    input  logic       botonreposar,
    input  logic       interaccion,
    input  logic       accion_ready,
    output logic       accion_valid,
    output logic [2:0] accion_id,
    output logic       rechazo,
    output logic       ocupado
);

    import planificador_acciones_pkg::*;

    localparam int             CDW      = (COOLDOWN_S < 1) ? 1 : $clog2(COOLDOWN_S + 1);
    localparam logic [CDW-1:0] CD_LOAD  = CDW'(COOLDOWN_S);
    localparam logic [1:0]     TICK_SAT = 2'(TICK_MAX);

    logic [5:0]     src;
    logic [5:0]     flanco;
    logic [1:0]     state;
    logic [5:1]     pend;
    logic [1:0]     tick_cnt;
    logic [CDW-1:0] cd [1:4];
    logic [2:0]     rr_ptr;

    logic           accept;
    logic           acc_tick;
    logic [5:1]     clr;
    logic [5:1]     in_cd;
    logic [5:1]     drop;
    logic [5:1]     merge;
    logic [5:1]     set_p;
    logic           rej;
    logic [2:0]     winner;

    assign src = {interaccion, botonreposar, botonpodar, botonabonar, botonregar, passsecond};

    for (genvar g = 0; g < 6; g++) begin : g_det
        detector_flanco u_det (
            .clk    (clk),
            .reset  (reset),
            .level  (src[g]),
            .flanco (flanco[g])
        );
    end

    // Cooldown is judged on the pre-load value, so a re-press in the accept cycle is allowed.
    always_comb begin
        accept   = (state == ST_OFFER) && accion_ready;
        acc_tick = accept && (accion_id == ACC_TICK);
        clr      = '0;
        in_cd    = '0;
        drop     = '0;
        merge    = '0;
        set_p    = '0;
        for (int i = 1; i <= 5; i++) begin
            clr[i]   = accept && (accion_id == 3'(i));
            if (i <= 4) in_cd[i] = (cd[i] != '0);
            drop[i]  = flanco[i] && in_cd[i];
            set_p[i] = flanco[i] && !in_cd[i];
            merge[i] = set_p[i] && pend[i] && !clr[i];
        end
        rej    = |(drop[4:1] | merge[4:1]);
        winner = (tick_cnt != 2'd0) ? ACC_TICK : rr_pick(pend, rr_ptr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            pend      <= '0;
            tick_cnt  <= 2'd0;
            rr_ptr    <= ACC_REGAR;
            accion_id <= ACC_TICK;
            rechazo   <= 1'b0;
            for (int i = 1; i <= 4; i++) cd[i] <= '0;
        end else begin
            rechazo <= rej;
            pend    <= (pend & ~clr) | set_p;

            if (acc_tick && !flanco[0])
                tick_cnt <= tick_cnt - 2'd1;
            else if (!acc_tick && flanco[0] && tick_cnt != TICK_SAT)
                tick_cnt <= tick_cnt + 2'd1;

            for (int i = 1; i <= 4; i++) begin
                if (clr[i])
                    cd[i] <= CD_LOAD;
                else if (flanco[0] && cd[i] != '0)
                    cd[i] <= cd[i] - 1'b1;
            end

            case (state)
                ST_IDLE: if (|pend || tick_cnt != 2'd0) state <= ST_ARB;
                ST_ARB: begin
                    accion_id <= winner;
                    state     <= ST_OFFER;
                end
                ST_OFFER: if (accion_ready) begin
                    state <= ST_IDLE;
                    if (accion_id != ACC_TICK)
                        rr_ptr <= (accion_id == ACC_INTERACCION) ? ACC_REGAR : accion_id + 3'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign accion_valid = (state == ST_OFFER);
    assign ocupado      = (state != ST_IDLE);

endmodule

// File: tb/tb_planificador_acciones.sv
// Directed bench for planificador_acciones: expected grant ids are queued by the stimulus
// and checked by a monitor at every valid/ready handshake.
module tb_planificador_acciones;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] btn = 6'b0;
    logic       rdy = 1'b0;
    logic       accion_valid;
    logic [2:0] accion_id;
    logic       rechazo;
    logic       ocupado;

    int         checks = 0;
    int         errors = 0;
    int         rej_cnt = 0;
    logic [2:0] exp_q[$];
    logic       bp_watch = 1'b0;
    logic       bp_bad = 1'b0;

    planificador_acciones dut (
        .clk          (clk),
        .reset        (reset),
        .passsecond   (btn[0]),
        .botonregar   (btn[1]),
        .botonabonar  (btn[2]),
        .botonpodar   (btn[3]),
        .botonreposar (btn[4]),
        .interaccion  (btn[5]),
        .accion_ready (rdy),
        .accion_valid (accion_valid),
        .accion_id    (accion_id),
        .rechazo      (rechazo),
        .ocupado      (ocupado)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [2:0] e;
        if (rechazo) rej_cnt++;
        if (bp_watch && (!accion_valid || accion_id != 3'd0)) bp_bad = 1'b1;
        if (!reset && accion_valid && rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL grant_unexpected: got id %0d, expected no grant", accion_id);
            end else begin
                e = exp_q.pop_front();
                if (accion_id !== e) begin
                    errors++;
                    $display("FAIL grant_id: got %0d, expected %0d", accion_id, e);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tap(input logic [5:0] m);
        btn = btn | m;
        step(1);
        btn = btn & ~m;
        step(1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        @(negedge clk);
        check("rst_valid", int'(accion_valid), 0);
        check("rst_id", int'(accion_id), 0);
        check("rst_ocupado", int'(ocupado), 0);
        check("rst_rechazo", int'(rechazo), 0);
        step(1);
    endtask

    initial begin
        int  r0;
        logic early;

        // Single press latency, ready tied high
        do_reset();
        rdy = 1'b1;
        btn[1] = 1'b1;
        exp_q.push_back(3'd1);
        early = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (accion_valid) early = 1'b1;
        end
        check("single_early_valid", int'(early), 0);
        @(negedge clk);
        check("single_valid_n3", int'(accion_valid), 1);
        @(negedge clk);
        check("single_valid_n4", int'(accion_valid), 0);
        check("single_ocupado_n4", int'(ocupado), 0);
        step(1);
        btn[1] = 1'b0;
        step(2);

        // Cooldown: two presses rejected, third after two ticks offered
        r0 = rej_cnt;
        tap(6'b000010);
        step(3);
        check("cd_reject_1", rej_cnt, r0 + 1);
        exp_q.push_back(3'd0);
        tap(6'b000001);
        step(6);
        tap(6'b000010);
        step(3);
        check("cd_reject_2", rej_cnt, r0 + 2);
        exp_q.push_back(3'd0);
        tap(6'b000001);
        step(6);
        exp_q.push_back(3'd1);
        tap(6'b000010);
        step(8);
        check("cd_offer_drained", exp_q.size(), 0);
        check("cd_no_extra_reject", rej_cnt, r0 + 2);

        // Simultaneous regar, abonar, podar and tick
        do_reset();
        rdy = 1'b1;
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd3);
        tap(6'b001111);
        step(25);
        check("simul_drained", exp_q.size(), 0);

        // Back-pressure with five ticks and a merged regar
        do_reset();
        rdy = 1'b0;
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd1);
        r0 = rej_cnt;
        tap(6'b000001);
        step(1);
        bp_bad = 1'b0;
        bp_watch = 1'b1;
        repeat (4) tap(6'b000001);
        tap(6'b000010);
        tap(6'b000010);
        step(8);
        bp_watch = 1'b0;
        check("bp_stable", int'(bp_bad), 0);
        check("bp_merge_reject", rej_cnt, r0 + 1);
        check("bp_no_grant_yet", exp_q.size(), 4);
        rdy = 1'b1;
        step(20);
        check("bp_drained", exp_q.size(), 0);

        // Round-robin between podar and interaccion
        do_reset();
        rdy = 1'b1;
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd5);
        tap(6'b101000);
        step(10);
        exp_q.push_back(3'd0);
        tap(6'b000001);
        step(6);
        exp_q.push_back(3'd0);
        tap(6'b000001);
        step(6);
        exp_q.push_back(3'd3);
        tap(6'b001000);
        step(8);
        exp_q.push_back(3'd0);
        tap(6'b000001);
        step(6);
        exp_q.push_back(3'd0);
        tap(6'b000001);
        step(6);
        exp_q.push_back(3'd5);
        exp_q.push_back(3'd3);
        tap(6'b101000);
        step(10);
        check("rr_drained", exp_q.size(), 0);

        // Reset during OFFER with abonar held
        do_reset();
        rdy = 1'b0;
        btn[2] = 1'b1;
        step(4);
        @(negedge clk);
        check("rst_offer_valid", int'(accion_valid), 1);
        check("rst_offer_id", int'(accion_id), 2);
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        @(negedge clk);
        check("rst_offer_dropped", int'(accion_valid), 0);
        rdy = 1'b1;
        step(10);
        check("rst_held_no_offer", int'(ocupado), 0);
        btn[2] = 1'b0;
        step(2);
        exp_q.push_back(3'd2);
        tap(6'b000100);
        step(8);
        check("rst_repress_drained", exp_q.size(), 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
